// File: rtl/accel_csr_axil.sv
// -----------------------------------------------------------------------------
// accel_csr_axil
//
// AXI4-Lite control/status register slave for the MobileViT accelerator. It
// sits in front of the tile scheduler and does the following:
//   - decodes host register accesses;
//   - stages a DESC_WORDS x 32-bit tile descriptor and hands it to the
//     scheduler over a valid/ready port;
//   - generates the start strobe and the soft-reset level;
//   - collects sticky done/error/overflow status and drives a level IRQ.
//
// Optional feature macro: ACCEL_CSR_PERF_CNT_EN
//   Defined   : TILE_COUNT (0x34) and CYCLE_COUNT (0x38) are saturating
//               32-bit performance counters.
//   Undefined : no counter flops are built; both addresses read as 0 (OKAY).
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*         AXI4-Lite write address, write data and response
//   s_axi_ar*/r*            AXI4-Lite read address and read data
//   desc_data               descriptor shadow; word i at [32i+31:32i]
//   desc_valid, desc_ready  descriptor handshake to the scheduler
//   start_pulse             one-cycle start strobe
//   soft_reset              level soft reset to the datapath
//   core_busy               scheduler busy level (reported live in STATUS)
//   core_done_pulse         single-cycle event, sets sticky done
//   core_error_pulse        single-cycle event, sets sticky error
//   tile_done_pulse         single-cycle event, counted by TILE_COUNT
//   irq                     level interrupt, IRQ_EN & (done | error)
// -----------------------------------------------------------------------------
module accel_csr_axil #(
    parameter int ADDR_LSB_W = 8,
    parameter int DESC_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [31:0]              s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,

    input  logic [31:0]              s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,

    output logic [32*DESC_WORDS-1:0] desc_data,
    output logic                     desc_valid,
    input  logic                     desc_ready,

    output logic                     start_pulse,
    output logic                     soft_reset,
    input  logic                     core_busy,
    input  logic                     core_done_pulse,
    input  logic                     core_error_pulse,
    input  logic                     tile_done_pulse,
    output logic                     irq
);

    // Register word indices (byte offset / 4).
    localparam int REG_CONTROL = 0;
    localparam int REG_STATUS  = 1;
    localparam int REG_DESC0   = 4;
    localparam int REG_PUSH    = 12;
    localparam int REG_TILE    = 13;
    localparam int REG_CYCLE   = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic is_mapped(input int idx);
        return (idx == REG_CONTROL) || (idx == REG_STATUS) ||
               ((idx >= REG_DESC0) && (idx < REG_DESC0 + DESC_WORDS)) ||
               (idx == REG_PUSH) || (idx == REG_TILE) || (idx == REG_CYCLE);
    endfunction

    // AXI channel state
    logic                     wr_acc_q, wr_acc_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     ar_acc_q, ar_acc_d;
    logic                     rvalid_q, rvalid_d;
    logic [1:0]               rresp_q, rresp_d;
    logic [31:0]              rdata_q, rdata_d;

    // Control / status state
    logic                     soft_rst_q, soft_rst_d;
    logic                     irq_en_q, irq_en_d;
    logic                     start_pulse_q, start_pulse_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     ovf_q, ovf_d;
    logic                     irq_q, irq_d;
    logic                     desc_valid_q, desc_valid_d;
    logic [32*DESC_WORDS-1:0] desc_data_q, desc_data_d;
    logic [31:0]              stage_q [DESC_WORDS];
    logic [31:0]              stage_d [DESC_WORDS];

`ifdef ACCEL_CSR_PERF_CNT_EN
    logic [31:0]              tile_cnt_q, tile_cnt_d;
    logic [31:0]              cycle_cnt_q, cycle_cnt_d;
`else
    logic                     perf_unused;
    assign perf_unused = tile_done_pulse;
`endif

    // Address bits outside the decoded window and the byte-lane bits are ignored.
    logic addr_unused;
    assign addr_unused = ^{s_axi_awaddr[31:ADDR_LSB_W], s_axi_awaddr[1:0],
                           s_axi_araddr[31:ADDR_LSB_W], s_axi_araddr[1:0]};

    // Decode helpers
    int   wr_idx;
    int   rd_idx;
    logic wr_hs;
    logic wr_b0;
    logic ctrl_wr;
    logic w1c_wr;
    logic push_req;
    logic push_ok;
    logic push_drop;
    logic [31:0] rd_val;

    always_comb begin
        // Defaults: hold state
        wr_acc_d      = 1'b0;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        ar_acc_d      = 1'b0;
        rvalid_d      = rvalid_q;
        rresp_d       = rresp_q;
        rdata_d       = rdata_q;
        soft_rst_d    = soft_rst_q;
        irq_en_d      = irq_en_q;
        start_pulse_d = 1'b0;
        done_d        = done_q;
        error_d       = error_q;
        ovf_d         = ovf_q;
        desc_valid_d  = desc_valid_q;
        desc_data_d   = desc_data_q;
        stage_d       = stage_q;
        rd_val        = 32'd0;

        wr_idx = int'(s_axi_awaddr[ADDR_LSB_W-1:2]);
        rd_idx = int'(s_axi_araddr[ADDR_LSB_W-1:2]);

        // ---- Write channel ----
        // Accept only when both AW and W are present and no response is pending;
        // the ready cycle itself is the handshake, so block re-acceptance then.
        wr_acc_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~wr_acc_q;
        wr_hs    = wr_acc_q;
        wr_b0    = wr_hs & s_axi_wstrb[0];

        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        ctrl_wr = wr_b0 && (wr_idx == REG_CONTROL);
        w1c_wr  = wr_b0 && (wr_idx == REG_STATUS);

        if (ctrl_wr) begin
            soft_rst_d = s_axi_wdata[1];
            irq_en_d   = s_axi_wdata[2];
        end
        // A start written together with SOFT_RST=1 is swallowed.
        start_pulse_d = ctrl_wr & s_axi_wdata[0] & ~s_axi_wdata[1];

        for (int i = 0; i < DESC_WORDS; i++) begin
            if (wr_hs && (wr_idx == REG_DESC0 + i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_axi_wstrb[b]) begin
                        stage_d[i][8*b +: 8] = s_axi_wdata[8*b +: 8];
                    end
                end
            end
        end

        // ---- Descriptor push ----
        // A push is refused only when the shadow is still owned by the scheduler
        // (valid and not being taken this very cycle).
        push_req  = wr_b0 && (wr_idx == REG_PUSH) && s_axi_wdata[0] && !soft_rst_q;
        push_ok   = push_req && (!desc_valid_q || desc_ready);
        push_drop = push_req && desc_valid_q && !desc_ready;

        if (push_ok) begin
            for (int i = 0; i < DESC_WORDS; i++) begin
                desc_data_d[32*i +: 32] = stage_q[i];
            end
        end

        // ---- Sticky status, set wins over write-1-to-clear ----
        if (soft_rst_q) begin
            desc_valid_d = 1'b0;
            done_d       = 1'b0;
            error_d      = 1'b0;
            ovf_d        = 1'b0;
        end else begin
            if (push_ok) begin
                desc_valid_d = 1'b1;
            end else if (desc_valid_q && desc_ready) begin
                desc_valid_d = 1'b0;
            end
            done_d  = core_done_pulse  | (done_q  & ~(w1c_wr & s_axi_wdata[1]));
            error_d = core_error_pulse | (error_q & ~(w1c_wr & s_axi_wdata[2]));
            ovf_d   = push_drop        | (ovf_q   & ~(w1c_wr & s_axi_wdata[4]));
        end

        irq_d = irq_en_q & (done_q | error_q);

`ifdef ACCEL_CSR_PERF_CNT_EN
        tile_cnt_d  = tile_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (soft_rst_q || start_pulse_q) begin
            tile_cnt_d  = 32'd0;
            cycle_cnt_d = 32'd0;
        end else begin
            if (tile_done_pulse && (tile_cnt_q != 32'hFFFF_FFFF)) begin
                tile_cnt_d = tile_cnt_q + 32'd1;
            end
            if (core_busy && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
        end
`endif

        // ---- Read channel ----
        ar_acc_d = s_axi_arvalid & ~rvalid_q & ~ar_acc_q;

        case (rd_idx)
            REG_CONTROL: rd_val = {29'd0, irq_en_q, soft_rst_q, 1'b0};
            REG_STATUS:  rd_val = {27'd0, ovf_q, desc_valid_q, error_q, done_q, core_busy};
            REG_PUSH:    rd_val = {31'd0, desc_valid_q};
`ifdef ACCEL_CSR_PERF_CNT_EN
            REG_TILE:    rd_val = tile_cnt_q;
            REG_CYCLE:   rd_val = cycle_cnt_q;
`endif
            default:     rd_val = 32'd0;
        endcase
        for (int i = 0; i < DESC_WORDS; i++) begin
            if (rd_idx == REG_DESC0 + i) begin
                rd_val = stage_q[i];
            end
        end

        if (ar_acc_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_acc_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            ar_acc_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rresp_q       <= 2'b00;
            rdata_q       <= 32'd0;
            soft_rst_q    <= 1'b0;
            irq_en_q      <= 1'b0;
            start_pulse_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            ovf_q         <= 1'b0;
            irq_q         <= 1'b0;
            desc_valid_q  <= 1'b0;
            desc_data_q   <= '0;
            for (int i = 0; i < DESC_WORDS; i++) begin
                stage_q[i] <= 32'd0;
            end
`ifdef ACCEL_CSR_PERF_CNT_EN
            tile_cnt_q    <= 32'd0;
            cycle_cnt_q   <= 32'd0;
`endif
        end else begin
            wr_acc_q      <= wr_acc_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            ar_acc_q      <= ar_acc_d;
            rvalid_q      <= rvalid_d;
            rresp_q       <= rresp_d;
            rdata_q       <= rdata_d;
            soft_rst_q    <= soft_rst_d;
            irq_en_q      <= irq_en_d;
            start_pulse_q <= start_pulse_d;
            done_q        <= done_d;
            error_q       <= error_d;
            ovf_q         <= ovf_d;
            irq_q         <= irq_d;
            desc_valid_q  <= desc_valid_d;
            desc_data_q   <= desc_data_d;
            stage_q       <= stage_d;
`ifdef ACCEL_CSR_PERF_CNT_EN
            tile_cnt_q    <= tile_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
`endif
        end
    end

    assign s_axi_awready = wr_acc_q;
    assign s_axi_wready  = wr_acc_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ar_acc_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign desc_data     = desc_data_q;
    assign desc_valid    = desc_valid_q;
    assign start_pulse   = start_pulse_q;
    assign soft_reset    = soft_rst_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_accel_csr_axil.sv
// -----------------------------------------------------------------------------
// tb_accel_csr_axil
//
// Directed self-checking bench for accel_csr_axil with hand-computed expected
// values. Honors ACCEL_CSR_PERF_CNT_EN for the counter expectations.
// -----------------------------------------------------------------------------
module tb_accel_csr_axil;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  s_axi_awaddr;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [31:0]  s_axi_araddr;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [255:0] desc_data;
    logic         desc_valid;
    logic         desc_ready;
    logic         start_pulse;
    logic         soft_reset;
    logic         core_busy;
    logic         core_done_pulse;
    logic         core_error_pulse;
    logic         tile_done_pulse;
    logic         irq;

    int n_cmp = 0;
    int n_err = 0;

    logic        st_after_hs;
    logic        st_next;
    logic        dv_after_hs;
    logic [1:0]  resp;
    logic [31:0] rd;

    logic [31:0] desc_vec [8];

    accel_csr_axil #(.ADDR_LSB_W(8), .DESC_WORDS(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axi_awaddr     (s_axi_awaddr),
        .s_axi_awvalid    (s_axi_awvalid),
        .s_axi_awready    (s_axi_awready),
        .s_axi_wdata      (s_axi_wdata),
        .s_axi_wstrb      (s_axi_wstrb),
        .s_axi_wvalid     (s_axi_wvalid),
        .s_axi_wready     (s_axi_wready),
        .s_axi_bresp      (s_axi_bresp),
        .s_axi_bvalid     (s_axi_bvalid),
        .s_axi_bready     (s_axi_bready),
        .s_axi_araddr     (s_axi_araddr),
        .s_axi_arvalid    (s_axi_arvalid),
        .s_axi_arready    (s_axi_arready),
        .s_axi_rdata      (s_axi_rdata),
        .s_axi_rresp      (s_axi_rresp),
        .s_axi_rvalid     (s_axi_rvalid),
        .s_axi_rready     (s_axi_rready),
        .desc_data        (desc_data),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .start_pulse      (start_pulse),
        .soft_reset       (soft_reset),
        .core_busy        (core_busy),
        .core_done_pulse  (core_done_pulse),
        .core_error_pulse (core_error_pulse),
        .tile_done_pulse  (tile_done_pulse),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full write transaction; optionally fires core_done_pulse on the handshake edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic pulse_done, output logic [1:0] r);
        logic ok;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (s_axi_awready && s_axi_wready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("wr_ready_seen", {31'd0, ok}, 32'd1);
        if (pulse_done) core_done_pulse = 1'b1;
        @(posedge clk); #1;
        core_done_pulse = 1'b0;
        s_axi_awvalid   = 1'b0;
        s_axi_wvalid    = 1'b0;
        st_after_hs     = start_pulse;
        dv_after_hs     = desc_valid;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (s_axi_bvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("bvalid_seen", {31'd0, ok}, 32'd1);
        r = s_axi_bresp;
        @(posedge clk); #1;
        st_next      = start_pulse;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ok;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (s_axi_arready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("ar_ready_seen", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (s_axi_rvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("rvalid_seen", {31'd0, ok}, 32'd1);
        d = s_axi_rdata;
        r = s_axi_rresp;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        desc_vec[0] = 32'h0010_0010; desc_vec[1] = 32'h0020_0020;
        desc_vec[2] = 32'h0040_0040; desc_vec[3] = 32'h0080_0080;
        desc_vec[4] = 32'h0100_0100; desc_vec[5] = 32'h0200_0200;
        desc_vec[6] = 32'h0400_0400; desc_vec[7] = 32'h8000_0000;

        rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; desc_ready = 1'b0;
        core_busy = 1'b0; core_done_pulse = 1'b0; core_error_pulse = 1'b0;
        tile_done_pulse = 1'b0;
        st_after_hs = 1'b0; st_next = 1'b0; dv_after_hs = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        check_val("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        check_val("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        check_val("rst_rdata",   s_axi_rdata,            32'd0);
        check_val("rst_desc",    {31'd0, |desc_data},    32'd0);
        check_val("rst_dvalid",  {31'd0, desc_valid},    32'd0);
        check_val("rst_ctrl",    {29'd0, start_pulse, soft_reset, irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Soft reset level
        axi_write(32'h00, 32'h2, 4'hF, 1'b0, resp);
        check_val("ctrl_bresp1", {30'd0, resp}, 32'd0);
        check_val("soft_rst_on", {31'd0, soft_reset}, 32'd1);
        axi_read(32'h04, rd, resp);
        check_val("status_soft", rd, 32'd0);
        check_val("status_rresp", {30'd0, resp}, 32'd0);
        axi_write(32'h00, 32'h0, 4'hF, 1'b0, resp);
        check_val("ctrl_bresp2", {30'd0, resp}, 32'd0);
        check_val("soft_rst_off", {31'd0, soft_reset}, 32'd0);

        // Descriptor staging and push
        for (int i = 0; i < 8; i++) begin
            axi_write(32'h10 + 32'(4 * i), desc_vec[i], 4'hF, 1'b0, resp);
        end
        axi_write(32'h30, 32'h1, 4'hF, 1'b0, resp);
        check_val("push_dv_next", {31'd0, dv_after_hs}, 32'd1);
        check_val("desc_word7", desc_data[255:224], 32'h8000_0000);
        check_val("desc_word0", desc_data[31:0],    32'h0010_0010);
        axi_read(32'h30, rd, resp);
        check_val("push_read", rd, 32'h1);

        // Byte strobes on staging
        axi_write(32'h14, 32'hAAAA_BBBB, 4'b0011, 1'b0, resp);
        axi_read(32'h14, rd, resp);
        check_val("stage_wstrb", rd, 32'h0020_BBBB);

        // Overflowing push
        axi_write(32'h30, 32'h1, 4'hF, 1'b0, resp);
        axi_read(32'h04, rd, resp);
        check_val("status_ovf", rd, 32'h18);
        check_val("desc_word1_kept", desc_data[63:32], 32'h0020_0020);
        axi_write(32'h04, 32'h10, 4'hF, 1'b0, resp);
        axi_read(32'h04, rd, resp);
        check_val("status_ovf_clr", rd, 32'h08);
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
        check_val("desc_taken", {31'd0, desc_valid}, 32'd0);

        // Start, counters, irq
        axi_write(32'h00, 32'h5, 4'hF, 1'b0, resp);
        check_val("start_hi", {31'd0, st_after_hs}, 32'd1);
        check_val("start_lo", {31'd0, st_next}, 32'd0);
        core_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tile_done_pulse = (i == 10) || (i == 40) || (i == 70);
            @(posedge clk); #1;
        end
        tile_done_pulse = 1'b0;
        core_busy       = 1'b0;
        core_done_pulse = 1'b1;
        @(posedge clk); #1;
        core_done_pulse = 1'b0;
        check_val("irq_1cyc", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check_val("irq_2cyc", {31'd0, irq}, 32'd1);
        axi_read(32'h38, rd, resp);
`ifdef ACCEL_CSR_PERF_CNT_EN
        check_val("cycle_count", rd, 32'd100);
`else
        check_val("cycle_count", rd, 32'd0);
`endif
        check_val("cycle_rresp", {30'd0, resp}, 32'd0);
        axi_read(32'h34, rd, resp);
`ifdef ACCEL_CSR_PERF_CNT_EN
        check_val("tile_count", rd, 32'd3);
`else
        check_val("tile_count", rd, 32'd0);
`endif
        axi_read(32'h04, rd, resp);
        check_val("status_done", rd, 32'h2);
        axi_write(32'h04, 32'h2, 4'hF, 1'b0, resp);
        check_val("irq_cleared", {31'd0, irq}, 32'd0);

        // Set beats W1C on the same edge
        axi_write(32'h04, 32'h2, 4'hF, 1'b1, resp);
        axi_read(32'h04, rd, resp);
        check_val("done_set_wins", rd, 32'h2);

        // Unmapped address
        axi_read(32'h40, rd, resp);
        check_val("unmapped_rdata", rd, 32'd0);
        check_val("unmapped_rresp", {30'd0, resp}, 32'd2);
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0, resp);
        check_val("unmapped_bresp", {30'd0, resp}, 32'd2);
        axi_read(32'h00, rd, resp);
        check_val("ctrl_unchanged", rd, 32'h4);
        axi_read(32'h10, rd, resp);
        check_val("desc0_unchanged", rd, 32'h0010_0010);

        // Soft reset clears sticky state, keeps staging
        axi_write(32'h00, 32'h6, 4'hF, 1'b0, resp);
        axi_read(32'h04, rd, resp);
        check_val("soft_clears_done", rd, 32'd0);
        check_val("soft_irq_low", {31'd0, irq}, 32'd0);
        axi_read(32'h1C, rd, resp);
        check_val("soft_keeps_stage", rd, 32'h0080_0080);
        axi_write(32'h00, 32'h0, 4'hF, 1'b0, resp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/accel_csr_axil.md
# accel_csr_axil

AXI4-Lite control/status register slave for the MobileViT accelerator: host-facing front end sitting directly upstream of the tile scheduler. It decodes host register accesses and stages a 256-bit tile descriptor, which it hands to the scheduler over a valid/ready port. It also generates start/soft-reset controls, collects sticky status and the IRQ, and optionally runs performance counters.

## Interface
- ADDR_LSB_W, default 8: number of low s_axi address bits decoded; upper bits ignored.
- DESC_WORDS, default 8: 32-bit words per descriptor.
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axi_awaddr / s_axi_awvalid / s_axi_awready  in/in/out  32/1/1  write address channel.
- s_axi_wdata / s_axi_wstrb / s_axi_wvalid / s_axi_wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp / s_axi_bvalid / s_axi_bready  out/out/in  2/1/1  write response.
- s_axi_araddr / s_axi_arvalid / s_axi_arready  in/in/out  32/1/1  read address.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out/out/out/in  32/2/1/1  read data.
- desc_data  out  32*DESC_WORDS  descriptor to scheduler; word i at bits [32i+31:32i].
- desc_valid / desc_ready  out/in  1/1  descriptor handshake.
- start_pulse  out  1  one-cycle start strobe to scheduler.
- soft_reset  out  1  level soft reset to datapath.
- core_busy  in  1  scheduler busy level.
- core_done_pulse / core_error_pulse / tile_done_pulse  in  1 each  single-cycle events.
- irq  out  1  level interrupt.

## Operation
- Register map (byte offsets): 0x00 CONTROL; 0x04 STATUS; 0x10+4i DESC_DATA[i], i=0..7; 0x30 DESC_PUSH; 0x34 TILE_COUNT; 0x38 CYCLE_COUNT.
- CONTROL: bit0 START write-1 produces start_pulse, reads 0; bit1 SOFT_RST RW level driving soft_reset; bit2 IRQ_EN RW.
- STATUS: bit0 busy (=core_busy, live); bit1 done, bit2 error, bit4 desc_overflow sticky, write-1-to-clear; bit3 desc_pending (=desc_valid). Other bits read 0.
- DESC_DATA[i]: RW staging registers; wstrb byte enables honoured.
- DESC_PUSH: write with wdata[0]=1 and wstrb[0]=1 copies all staging words into the desc_data shadow and sets desc_valid. If desc_valid=1 and desc_ready=0 that cycle, push dropped, shadow unchanged, desc_overflow set. Reads return {31'b0, desc_valid}.
- desc_valid clears on desc_valid&desc_ready unless a push lands the same cycle (then it stays 1 with the new shadow, no overflow). desc_data stable while desc_valid=1.
- START, W1C and PUSH act only when wstrb[0]=1.
- Sticky set beats W1C clear in the same cycle.
- irq = registered IRQ_EN & (done | error).
- SOFT_RST=1: desc_valid, done, error, desc_overflow and counters held at 0; start_pulse suppressed; CONTROL and DESC_DATA retained.
- Unmapped address: write ignored, read data 0, resp SLVERR (2'b10); mapped accesses resp OKAY (2'b00). Writes to RO registers ignored with OKAY.

## Timing
- All outputs reset to 0: AXI ready/valid/resp/rdata, desc_data, desc_valid, start_pulse, soft_reset, irq. All registers reset to 0.
- Write: awvalid&wvalid both sampled high with bvalid=0 at edge N -> awready=wready=1 for the single cycle after edge N; register update at the handshake edge; bvalid rises the next cycle, held until bready. No new write accepted while bvalid=1. AW-only or W-only waits.
- Read: arvalid sampled with rvalid=0 -> arready one cycle; rdata/rresp registered, rvalid the following cycle, held stable until rready.
- start_pulse high exactly one cycle, the cycle after the CONTROL write handshake. desc_valid rises the cycle after the DESC_PUSH handshake.
- irq rises 2 cycles after core_done_pulse (sticky set + irq register).
- Simultaneous read and write: independent; read returns pre-write value if same edge.
- Async reset mid-transaction drops it; no response issued.

## Configuration
- ACCEL_CSR_PERF_CNT_EN defined: TILE_COUNT increments on tile_done_pulse; CYCLE_COUNT increments each cycle core_busy=1; both 32-bit, cleared on start_pulse and SOFT_RST, saturate at 0xFFFF_FFFF.
- Undefined: no counter flops; 0x34/0x38 read 0 with OKAY.

## Test plan
- Write 0x00=0x2 then 0x00=0x0 -> soft_reset high between writes; read 0x04 returns 0x0; bresp 2'b00 both.
- Write DESC_DATA 0x10..0x2C with 0x0010_0010..0x8000_0000, push 0x30=1, desc_ready=0 -> desc_valid=1, desc_data word7=0x8000_0000, word0=0x0010_0010; read 0x30 = 0x1.
- With desc_valid=1, desc_ready=0, push again -> STATUS bit4=1, desc_data unchanged; W1C 0x04=0x10 clears it.
- CONTROL=0x5 (START+IRQ_EN), core_busy high 100 cycles, 3 tile_done pulses, core_done_pulse -> irq rises 2 cycles later; CYCLE_COUNT=100, TILE_COUNT=3 (macro on) or 0 (off); W1C 0x04=0x2 drops irq.
- core_done_pulse same cycle as W1C of bit1 -> done stays 1.
- Read 0x40 -> rdata 0, rresp 2'b10; write 0x40 -> bresp 2'b10, no register changes.
